// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory arbiter slice: FSM state encoding,
// requester IDs, the full-word byte-enable constant and the default
// timeout / starvation limits used by mem_arb.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] RID_IF  = 2'd0;
    localparam logic [1:0] RID_DM  = 2'd1;
    localparam logic [1:0] RID_DBG = 2'd2;

    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int DEF_TIMEOUT_CYC = 16;
    localparam int DEF_STARVE_LIM  = 4;

endpackage

// File: rtl/arb_pick.sv
// arb_pick
// Combinational winner selection for the memory arbiter.
// Ports:
//   if_req, dm_req, dbg_req : current requests from the three masters
//   if_starve, dbg_starve   : loss counter of IF / DBG has reached its limit
//   rid                     : ID of the winning requester (RID_*)
//   valid                   : at least one request is present
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       dbg_req,
    input  logic       if_starve,
    input  logic       dbg_starve,
    output logic [1:0] rid,
    output logic       valid
);

    // A starved port only overrides while it is actually requesting; IF is
    // checked first so it wins when both starved ports are present.
    always_comb begin
        valid = if_req | dm_req | dbg_req;
        rid   = RID_DM;
        if (if_req && if_starve) begin
            rid = RID_IF;
        end else if (dbg_req && dbg_starve) begin
            rid = RID_DBG;
        end else if (dm_req) begin
            rid = RID_DM;
        end else if (if_req) begin
            rid = RID_IF;
        end else if (dbg_req) begin
            rid = RID_DBG;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb
// Single-port memory arbiter/sequencer for the multicycle CPU. Shares one
// memory port between instruction fetch (IF), data load/store (DM) and the
// debug loader (DBG), running one transaction at a time:
//   IDLE -> (grant, register payload) -> BUSY -> (mem_rdy or timeout) -> RESP
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   if_req/if_addr/if_ack        : fetch port (read-only, full word)
//   dm_*  / dm_ack               : data port (load/store with byte enables)
//   dbg_* / dbg_ack              : debug port, same shape as dm_*
//   rdata, err                   : response data/status, valid with any ack
//   mem_req/we/be/addr/wdata     : memory request side, held until mem_rdy
//   mem_rdata, mem_rdy           : memory response side
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int STARVE_LIM  = DEF_STARVE_LIM
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [3:0]    dbg_be,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,

    output logic [DW-1:0] rdata,
    output logic          err,

    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy
);

    // The timeout counter counts BUSY cycles already spent; reaching
    // TIMEOUT_CYC-1 on a cycle without mem_rdy means this is the last one.
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] STARVE_Q = 4'(STARVE_LIM);

    state_t        state_q, state_d;
    logic [1:0]    rid_q, rid_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic [3:0]    if_cnt_q, if_cnt_d;
    logic [3:0]    dbg_cnt_q, dbg_cnt_d;

    logic [1:0]    pick_rid;
    logic          pick_valid;

    arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .dbg_req    (dbg_req),
        .if_starve  (if_cnt_q == STARVE_Q),
        .dbg_starve (dbg_cnt_q == STARVE_Q),
        .rid        (pick_rid),
        .valid      (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        rid_d       = rid_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tcnt_d      = tcnt_q;
        if_cnt_d    = if_cnt_q;
        dbg_cnt_d   = dbg_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d   = ST_BUSY;
                    rid_d     = pick_rid;
                    mem_req_d = 1'b1;
                    tcnt_d    = '0;

                    case (pick_rid)
                        RID_IF: begin
                            mem_we_d    = 1'b0;
                            mem_be_d    = BE_WORD;
                            mem_addr_d  = if_addr;
                            mem_wdata_d = '0;
                        end
                        RID_DM: begin
                            mem_we_d    = dm_we;
                            mem_be_d    = dm_be;
                            mem_addr_d  = dm_addr;
                            mem_wdata_d = dm_wdata;
                        end
                        default: begin
                            mem_we_d    = dbg_we;
                            mem_be_d    = dbg_be;
                            mem_addr_d  = dbg_addr;
                            mem_wdata_d = dbg_wdata;
                        end
                    endcase

                    // Loss counters saturate at the limit so the starve flag
                    // stays asserted until the port is finally granted.
                    if (pick_rid == RID_IF) begin
                        if_cnt_d = '0;
                    end else if (if_req && (if_cnt_q != STARVE_Q)) begin
                        if_cnt_d = if_cnt_q + 4'd1;
                    end

                    if (pick_rid == RID_DBG) begin
                        dbg_cnt_d = '0;
                    end else if (dbg_req && (dbg_cnt_q != STARVE_Q)) begin
                        dbg_cnt_d = dbg_cnt_q + 4'd1;
                    end
                end
            end

            ST_BUSY: begin
                // mem_rdy is checked first so it beats a same-cycle timeout.
                if (mem_rdy) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_we_q ? '0 : mem_rdata;
                    err_d     = 1'b0;
                end else if (tcnt_q == TO_LAST) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rid_q       <= RID_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tcnt_q      <= '0;
            if_cnt_q    <= '0;
            dbg_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rid_q       <= rid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tcnt_q      <= tcnt_d;
            if_cnt_q    <= if_cnt_d;
            dbg_cnt_q   <= dbg_cnt_d;
        end
    end

    // Acks are decoded from the RESP state so exactly one fires per transaction.
    assign if_ack    = (state_q == ST_RESP) && (rid_q == RID_IF);
    assign dm_ack    = (state_q == ST_RESP) && (rid_q == RID_DM);
    assign dbg_ack   = (state_q == ST_RESP) && (rid_q == RID_DBG);

    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
